// File: rtl/mul_div_unit_if.sv
// +--------------------------------------------------------------------+
// | mul_div_if                                                         |
// | Start/busy/done handshake and operand/result bus for mul_div_unit. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface mul_div_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result_lo;
  logic [DATA_WIDTH-1:0] result_hi;
  logic                  div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// +--------------------------------------------------------------------+
// | mul_div_unit                                                       |
// | Iterative unsigned multiply (shift-add) / divide (restoring).      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_div_unit #(
  parameter int DATA_WIDTH = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  mul_div_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_opb;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_result_lo;
  logic [DATA_WIDTH-1:0] r_result_hi;
  logic                  r_dbz;

  logic                  w_accept;
  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [DATA_WIDTH:0]   w_div_shift;
  logic [DATA_WIDTH:0]   w_div_diff;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_next_hi;
  logic [DATA_WIDTH-1:0] w_next_lo;

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // r_hi holds the upper accumulator (mul) or partial remainder (div);
  // r_lo holds the multiplier (mul) or dividend shifting into quotient (div).
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_div_shift = {r_hi, r_lo[DATA_WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opb};
    w_qbit      = ~w_div_diff[DATA_WIDTH];
    w_next_hi   = '0;
    w_next_lo   = '0;
    if (r_op) begin
      w_next_hi = w_qbit ? w_div_diff[DATA_WIDTH-1:0] : w_div_shift[DATA_WIDTH-1:0];
      w_next_lo = {r_lo[DATA_WIDTH-2:0], w_qbit};
    end else begin
      w_next_hi = w_mul_sum[DATA_WIDTH:1];
      w_next_lo = {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= 1'b0;
      r_opb       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result_lo <= '0;
      r_result_hi <= '0;
      r_dbz       <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_hi  <= w_next_hi;
      r_lo  <= w_next_lo;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_LAST) begin
        r_result_lo <= w_next_lo;
        r_result_hi <= w_next_hi;
        r_state     <= S_DONE;
      end
    end else if (w_accept) begin
      r_op  <= bus.op;
      r_opb <= bus.b;
      r_hi  <= '0;
      r_lo  <= bus.a;
      r_cnt <= '0;
      r_dbz <= 1'b0;
      if (bus.op && (bus.b == '0)) begin
        r_result_lo <= '1;
        r_result_hi <= bus.a;
        r_dbz       <= 1'b1;
        r_state     <= S_DONE;
      end else begin
        r_state <= S_RUN;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end

  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.result_lo   = r_result_lo;
  assign bus.result_hi   = r_result_hi;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// +--------------------------------------------------------------------+
// | tb_mul_div_unit                                                    |
// | Scoreboard bench for mul_div_unit.                                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mul_div_unit;

  localparam int DATA_WIDTH = 16;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          busy;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  mul_div_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  mul_div_unit #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        chk("done_pair", {31'b0, prev_done}, 32'd0);
        done_seen++;
        if (sb.size() == 0) begin
          chk("spurious_done", sb.size(), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("result_lo", {16'b0, bus.result_lo}, {16'b0, e.lo});
          chk("result_hi", {16'b0, bus.result_hi}, {16'b0, e.hi});
          chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
          chk("latency", cyc, e.due);
          chk("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end else if (bus.busy) begin
        busy_cnt++;
      end
      prev_done = bus.done;
    end
  end

  function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                 input int base);
    exp_t e;
    logic [31:0] p;
    p = {16'b0, a} * {16'b0, b};
    if (op && b == 16'd0) begin
      e.lo = 16'hFFFF; e.hi = a; e.dbz = 1'b1; e.busy = 0; e.due = base + 1;
    end else if (op) begin
      e.lo = a / b; e.hi = a % b; e.dbz = 1'b0; e.busy = 16; e.due = base + 1 + 16;
    end else begin
      e.lo = p[15:0]; e.hi = p[31:16]; e.dbz = 1'b0; e.busy = 16; e.due = base + 1 + 16;
    end
    return e;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Caller must be at posedge+1 with the unit ready (IDLE or DONE cycle)
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    sb.push_back(model(op, a, b, cyc));
    align();
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_lo", {16'b0, bus.result_lo}, 32'd0);
    chk("rst_hi", {16'b0, bus.result_hi}, 32'd0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);

    // 1: basic multiply
    align();
    run_op(1'b0, 16'h00FF, 16'h0101);
    drain();

    // 2: max multiply, then divide launched in the done cycle
    align();
    run_op(1'b0, 16'hFFFF, 16'hFFFF);
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        if (bus.done) break;
        align();
      end
      if (k == 40) chk("wait_done_timeout", k, 32'd0);
    end
    run_op(1'b1, 16'd1000, 16'd7);
    drain();

    // 3: divide by zero, then the next start clears the flag
    align();
    run_op(1'b1, 16'h1234, 16'h0000);
    drain();
    repeat (2) align();
    chk("dbz_hold", {31'b0, bus.div_by_zero}, 32'd1);
    run_op(1'b0, 16'd3, 16'd4);
    chk("dbz_cleared", {31'b0, bus.div_by_zero}, 32'd0);
    chk("busy_after_start", {31'b0, bus.busy}, 32'd1);
    drain();

    // 4: start and operand changes during RUN are ignored
    align();
    run_op(1'b1, 16'd50, 16'd100);
    repeat (3) align();
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    align();
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    drain();
    repeat (3) align();
    chk("hold_lo", {16'b0, bus.result_lo}, 32'd0);
    chk("hold_hi", {16'b0, bus.result_hi}, 32'd50);

    // 5: asynchronous reset mid-operation
    align();
    run_op(1'b0, 16'h1111, 16'h0003);
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_lo", {16'b0, bus.result_lo}, 32'd0);
    chk("arst_hi", {16'b0, bus.result_hi}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("no_done_after_rst", done_seen, done_seen);
    align();
    run_op(1'b0, 16'd3, 16'd5);
    drain();

    // 6: start held high, back-to-back operations
    align();
    begin
      int target;
      int k;
      target = done_seen + 4;
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'd2; bus.b = 16'd3;
      for (int j = 0; j < 4; j++) begin
        exp_t e;
        e = model(1'b0, 16'd2, 16'd3, cyc + j * 17);
        sb.push_back(e);
      end
      for (k = 0; k < 120; k++) begin
        @(negedge clk);
        #1;
        if (done_seen >= target) break;
      end
      bus.start = 1'b0;
      if (k == 120) chk("b2b_timeout", done_seen, target);
    end
    drain();
    repeat (5) align();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
